// File: rtl/kf_ctrl_pkg.sv
// Shared constants for the Kalman step controller: sizes, stage indices, masks, FSM encodings.
// Used by kf_step_ctrl and kf_next_stage; watchdog option is KF_STAGE_WDOG_EN in the top.
package kf_ctrl_pkg;

  localparam int unsigned NSTAGE  = 5;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned TMO_CYC = 64;
  localparam int unsigned WD_W    = $clog2(TMO_CYC);
  localparam int unsigned ST_W    = 3;

  localparam logic [IDX_W-1:0] STG_PRED  = 3'd0;
  localparam logic [IDX_W-1:0] STG_PCOV  = 3'd1;
  localparam logic [IDX_W-1:0] STG_GAIN  = 3'd2;
  localparam logic [IDX_W-1:0] STG_XPOST = 3'd3;
  localparam logic [IDX_W-1:0] STG_PPOST = 3'd4;

  localparam logic [NSTAGE-1:0] PRED_MASK = 5'b00011;
  localparam logic [NSTAGE-1:0] ALL_MASK  = 5'b11111;

  localparam logic [ST_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [ST_W-1:0] ST_ISSUE  = 3'd1;
  localparam logic [ST_W-1:0] ST_WAIT   = 3'd2;
  localparam logic [ST_W-1:0] ST_COMMIT = 3'd3;
  localparam logic [ST_W-1:0] ST_OUT    = 3'd4;

endpackage

// File: rtl/kf_next_stage.sv
// Combinational priority finder: lowest set mask bit at or above 'from', plus a none flag.
module kf_next_stage
  import kf_ctrl_pkg::*;
(
  input  logic [NSTAGE-1:0] mask,
  input  logic [IDX_W-1:0]  from,
  output logic [IDX_W-1:0]  nxt_c,
  output logic              none_c
);

  // Scan high to low so the lowest qualifying bit is the last one written.
  always_comb begin
    nxt_c  = '0;
    none_c = 1'b1;
    for (int i = NSTAGE - 1; i >= 0; i--) begin
      if (mask[i] && (IDX_W'(i) >= from)) begin
        nxt_c  = IDX_W'(i);
        none_c = 1'b0;
      end
    end
  end

endmodule

// File: rtl/kf_step_ctrl.sv
// Sequencer for one 2x2 fixed-point Kalman iteration: issues stage starts, commits, hands off result.
// Define KF_STAGE_WDOG_EN to add the per-stage watchdog and the tmo_stage output.
module kf_step_ctrl
  import kf_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              meas_valid,
  input  logic              predict_only,
  output logic              meas_ready,
  output logic [NSTAGE-1:0] stg_start,
  input  logic [NSTAGE-1:0] stg_done,
  output logic              commit,
  output logic              commit_prior_only,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  iter_cnt,
  output logic              err
`ifdef KF_STAGE_WDOG_EN
  ,
  output logic [2:0]        tmo_stage
`endif
);

  logic [ST_W-1:0]   state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [NSTAGE-1:0] mask_q, mask_d;
  logic              pred_q, pred_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  iter_cnt_q, iter_cnt_d;
  logic              meas_ready_q, meas_ready_d;
  logic              busy_q, busy_d;
  logic [NSTAGE-1:0] stg_start_q, stg_start_d;
  logic              commit_q, commit_d;
  logic              cpo_q, cpo_d;
  logic              res_valid_q, res_valid_d;

  logic [NSTAGE-1:0] fs_mask_c, cur_oh_c;
  logic [IDX_W-1:0]  fs_from_c, nxt_c;
  logic              none_c, done_hit_c, spur_c;

`ifdef KF_STAGE_WDOG_EN
  logic [WD_W-1:0]   wd_cnt_q, wd_cnt_d;
  logic [IDX_W-1:0]  tmo_stage_q, tmo_stage_d;
`endif

  assign cur_oh_c   = NSTAGE'(1) << idx_q;
  assign done_hit_c = |(stg_done & cur_oh_c);
  assign spur_c     = |(stg_done & ~cur_oh_c);

  // In IDLE the finder sees the mask about to be latched; otherwise it looks above idx.
  assign fs_mask_c = (state_q == ST_IDLE) ? (predict_only ? PRED_MASK : ALL_MASK) : mask_q;
  assign fs_from_c = (state_q == ST_IDLE) ? STG_PRED : idx_q + IDX_W'(1);

  kf_next_stage u_next_stage (
    .mask   (fs_mask_c),
    .from   (fs_from_c),
    .nxt_c  (nxt_c),
    .none_c (none_c)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    mask_d     = mask_q;
    pred_d     = pred_q;
    err_d      = err_q;
    iter_cnt_d = iter_cnt_q;
`ifdef KF_STAGE_WDOG_EN
    wd_cnt_d    = wd_cnt_q;
    tmo_stage_d = tmo_stage_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (meas_valid && meas_ready_q) begin
          mask_d  = fs_mask_c;
          pred_d  = predict_only;
          idx_d   = nxt_c;
          state_d = none_c ? ST_COMMIT : ST_ISSUE;
`ifdef KF_STAGE_WDOG_EN
          tmo_stage_d = '0;
`endif
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
`ifdef KF_STAGE_WDOG_EN
        wd_cnt_d = '0;
`endif
      end
      ST_WAIT: begin
        if (spur_c) err_d = 1'b1;
        if (done_hit_c) begin
          idx_d   = nxt_c;
          state_d = none_c ? ST_COMMIT : ST_ISSUE;
        end
`ifdef KF_STAGE_WDOG_EN
        else if (wd_cnt_q == WD_W'(TMO_CYC - 1)) begin
          err_d       = 1'b1;
          tmo_stage_d = idx_q;
          state_d     = ST_OUT;
        end else begin
          wd_cnt_d = wd_cnt_q + WD_W'(1);
        end
`endif
      end
      ST_COMMIT: begin
        iter_cnt_d = iter_cnt_q + CNT_W'(1);
        state_d    = ST_OUT;
      end
      ST_OUT: begin
        if (res_valid_q && res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered from the next state; the start pulse follows the ISSUE cycle.
    meas_ready_d = (state_d == ST_IDLE);
    busy_d       = (state_d != ST_IDLE);
    stg_start_d  = (state_q == ST_ISSUE) ? cur_oh_c : '0;
    commit_d     = (state_d == ST_COMMIT);
    cpo_d        = (state_d == ST_COMMIT) && pred_q;
    res_valid_d  = (state_d == ST_OUT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= STG_PRED;
      mask_q       <= ALL_MASK;
      pred_q       <= 1'b0;
      err_q        <= 1'b0;
      iter_cnt_q   <= '0;
      meas_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      stg_start_q  <= '0;
      commit_q     <= 1'b0;
      cpo_q        <= 1'b0;
      res_valid_q  <= 1'b0;
`ifdef KF_STAGE_WDOG_EN
      wd_cnt_q     <= '0;
      tmo_stage_q  <= '0;
`endif
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      mask_q       <= mask_d;
      pred_q       <= pred_d;
      err_q        <= err_d;
      iter_cnt_q   <= iter_cnt_d;
      meas_ready_q <= meas_ready_d;
      busy_q       <= busy_d;
      stg_start_q  <= stg_start_d;
      commit_q     <= commit_d;
      cpo_q        <= cpo_d;
      res_valid_q  <= res_valid_d;
`ifdef KF_STAGE_WDOG_EN
      wd_cnt_q     <= wd_cnt_d;
      tmo_stage_q  <= tmo_stage_d;
`endif
    end
  end

  assign meas_ready        = meas_ready_q;
  assign busy              = busy_q;
  assign stg_start         = stg_start_q;
  assign commit            = commit_q;
  assign commit_prior_only = cpo_q;
  assign res_valid         = res_valid_q;
  assign iter_cnt          = iter_cnt_q;
  assign err               = err_q;
`ifdef KF_STAGE_WDOG_EN
  assign tmo_stage         = tmo_stage_q;
`endif

endmodule

// File: tb/tb_kf_step_ctrl.sv
// Self-checking bench for kf_step_ctrl: randomized stage latencies against a behavioural model.
// Watchdog scenario is built only when KF_STAGE_WDOG_EN is defined.
module tb_kf_step_ctrl;
  import kf_ctrl_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              meas_valid = 1'b0;
  logic              predict_only = 1'b0;
  logic              meas_ready;
  logic [NSTAGE-1:0] stg_start;
  logic [NSTAGE-1:0] stg_done = '0;
  logic              commit;
  logic              commit_prior_only;
  logic              res_valid;
  logic              res_ready = 1'b0;
  logic              busy;
  logic [CNT_W-1:0]  iter_cnt;
  logic              err;
`ifdef KF_STAGE_WDOG_EN
  logic [2:0]        tmo_stage;
`endif

  kf_step_ctrl dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .meas_valid        (meas_valid),
    .predict_only      (predict_only),
    .meas_ready        (meas_ready),
    .stg_start         (stg_start),
    .stg_done          (stg_done),
    .commit            (commit),
    .commit_prior_only (commit_prior_only),
    .res_valid         (res_valid),
    .res_ready         (res_ready),
    .busy              (busy),
    .iter_cnt          (iter_cnt),
    .err               (err)
`ifdef KF_STAGE_WDOG_EN
    ,
    .tmo_stage         (tmo_stage)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  int lat[NSTAGE];
  int iter_m = 0;
  bit err_m  = 1'b0;

  // Observations gathered by run_iter
  int obs_order[$];
  int obs_lat;
  int obs_ncommit;
  bit obs_cpo, obs_onehot_ok, obs_bp_ok, obs_after_ok, obs_busy_ok;

  function automatic bit stage_runs(input bit pred, input int i);
    return !pred || (i < 2);
  endfunction

  function automatic int ref_lat(input bit pred);
    int s = 1;
    for (int i = 0; i < NSTAGE; i++) if (stage_runs(pred, i)) s += lat[i] + 2;
    return s;
  endfunction

  function automatic bit order_ok(input bit pred);
    int exp_q[$];
    for (int i = 0; i < NSTAGE; i++) if (stage_runs(pred, i)) exp_q.push_back(i);
    if (exp_q.size() != obs_order.size()) return 1'b0;
    foreach (exp_q[i]) if (exp_q[i] != obs_order[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic rand_lat(input int lo, input int hi);
    for (int i = 0; i < NSTAGE; i++) lat[i] = int'($urandom_range(hi, lo));
  endtask

  // Drives one measurement, emulates the stage engines and the result consumer.
  task automatic run_iter(input bit pred, input int bp, input bit spur, input int abort_stg,
                          input int dead_stg);
    int due[NSTAGE];
    int k, r, spur_at, n;
    bit fin;
    obs_order.delete();
    obs_lat = -1; obs_ncommit = 0; obs_cpo = 1'b0;
    obs_onehot_ok = 1'b1; obs_bp_ok = 1'b1; obs_after_ok = 1'b0; obs_busy_ok = 1'b0;
    for (int i = 0; i < NSTAGE; i++) due[i] = -1;
    r = -1; spur_at = -1; fin = 1'b0; n = 0;
    @(negedge clk);
    while (meas_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    meas_valid = 1'b1; predict_only = pred; res_ready = 1'b0;
    k = 0;
    while (!fin && k < 3000) begin
      @(negedge clk); k++;
      if (k == 1) begin
        meas_valid   = 1'b0;
        predict_only = 1'($urandom);
        obs_busy_ok  = (busy === 1'b1) && (meas_ready === 1'b0);
      end
      if (stg_start !== '0 && $countones(stg_start) != 1) obs_onehot_ok = 1'b0;
      for (int i = 0; i < NSTAGE; i++) begin
        if (stg_start[i] === 1'b1) begin
          obs_order.push_back(i);
          if (i != dead_stg) due[i] = k + lat[i];
          if (spur && i == int'(STG_PCOV)) spur_at = k + 1;
        end
      end
      if (commit === 1'b1) begin obs_ncommit++; obs_cpo = commit_prior_only; end
      if (abort_stg >= 0 && obs_order.size() > 0 && obs_order[$] == abort_stg) begin
        rst_n = 1'b0;
        fin   = 1'b1;
      end else if (r < 0 && res_valid === 1'b1) begin
        r = k; obs_lat = k - 1;
      end
      if (r >= 0 && !fin) begin
        if (k - r <= bp) begin
          if (res_valid !== 1'b1 || meas_ready !== 1'b0) obs_bp_ok = 1'b0;
          res_ready = (k - r == bp);
        end else begin
          res_ready    = 1'b0;
          obs_after_ok = (meas_ready === 1'b1) && (res_valid === 1'b0) && (busy === 1'b0);
          fin          = 1'b1;
        end
      end
      stg_done = '0;
      if (!fin) begin
        for (int i = 0; i < NSTAGE; i++) if (due[i] == k) stg_done[i] = 1'b1;
        if (k == spur_at) stg_done[STG_XPOST] = 1'b1;
      end
    end
    stg_done = '0; res_ready = 1'b0;
    n_checks++;
    if (!fin) $display("FAIL iter_budget: iteration not finished after %0d cycles, want finish", k);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({meas_ready, busy, commit, commit_prior_only, res_valid, err} !== 6'b0)
      $display("FAIL reset_ctrl: got %b want 000000",
               {meas_ready, busy, commit, commit_prior_only, res_valid, err});
    else n_pass++;
    n_checks++;
    if (stg_start !== '0 || iter_cnt !== '0)
      $display("FAIL reset_data: stg_start=%b iter_cnt=%0d want 0/0", stg_start, iter_cnt);
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (meas_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL reset_release: meas_ready=%b busy=%b want 1/0", meas_ready, busy);
    else n_pass++;
  endtask

  task automatic test_full();
    for (int i = 0; i < NSTAGE; i++) lat[i] = 8;
    run_iter(1'b0, 0, 1'b0, -1, -1);
    iter_m++;
    n_checks++;
    if (!order_ok(1'b0) || !obs_onehot_ok)
      $display("FAIL full_order: got %0d starts onehot=%0d want 5 in order", obs_order.size(), obs_onehot_ok);
    else n_pass++;
    n_checks++;
    if (obs_ncommit != 1 || obs_cpo !== 1'b0)
      $display("FAIL full_commit: got %0d commits prior=%0d want 1/0", obs_ncommit, obs_cpo);
    else n_pass++;
    n_checks++;
    if (obs_lat != ref_lat(1'b0)) $display("FAIL full_latency: got %0d want %0d", obs_lat, ref_lat(1'b0));
    else n_pass++;
    n_checks++;
    if (iter_cnt !== CNT_W'(iter_m)) $display("FAIL full_iter_cnt: got %0d want %0d", iter_cnt, iter_m);
    else n_pass++;
    n_checks++;
    if (!obs_busy_ok || err !== err_m) $display("FAIL full_busy_err: busy_ok=%0d err=%b want 1/%b", obs_busy_ok, err, err_m);
    else n_pass++;
  endtask

  task automatic test_predict();
    for (int i = 0; i < NSTAGE; i++) lat[i] = 8;
    run_iter(1'b1, 0, 1'b0, -1, -1);
    iter_m++;
    n_checks++;
    if (!order_ok(1'b1)) $display("FAIL pred_order: got %0d starts want 2", obs_order.size());
    else n_pass++;
    n_checks++;
    if (obs_ncommit != 1 || obs_cpo !== 1'b1)
      $display("FAIL pred_commit: got %0d commits prior=%0d want 1/1", obs_ncommit, obs_cpo);
    else n_pass++;
    n_checks++;
    if (obs_lat != ref_lat(1'b1)) $display("FAIL pred_latency: got %0d want %0d", obs_lat, ref_lat(1'b1));
    else n_pass++;
    n_checks++;
    if (iter_cnt !== CNT_W'(iter_m)) $display("FAIL pred_iter_cnt: got %0d want %0d", iter_cnt, iter_m);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    rand_lat(1, 6);
    run_iter(1'b0, 10, 1'b0, -1, -1);
    iter_m++;
    n_checks++;
    if (!obs_bp_ok) $display("FAIL bp_hold: res_valid/meas_ready not held at 1/0 got bad=%0d want bad=0", !obs_bp_ok);
    else n_pass++;
    n_checks++;
    if (!obs_after_ok) $display("FAIL bp_release: after handshake ok=%0d want 1", obs_after_ok);
    else n_pass++;
    n_checks++;
    if (obs_lat != ref_lat(1'b0)) $display("FAIL bp_latency: got %0d want %0d", obs_lat, ref_lat(1'b0));
    else n_pass++;
  endtask

  task automatic test_spurious();
    rand_lat(2, 9);
    run_iter(1'b0, 1, 1'b1, -1, -1);
    iter_m++;
    err_m = 1'b1;
    n_checks++;
    if (err !== err_m) $display("FAIL spur_err: got %b want %b", err, err_m);
    else n_pass++;
    n_checks++;
    if (!order_ok(1'b0) || obs_ncommit != 1)
      $display("FAIL spur_sequence: got %0d starts %0d commits want 5/1", obs_order.size(), obs_ncommit);
    else n_pass++;
    n_checks++;
    if (iter_cnt !== CNT_W'(iter_m)) $display("FAIL spur_iter_cnt: got %0d want %0d", iter_cnt, iter_m);
    else n_pass++;
  endtask

  task automatic test_random();
    bit p;
    int bp;
    for (int it = 0; it < 6; it++) begin
      rand_lat(1, 12);
      p  = 1'($urandom);
      bp = int'($urandom_range(4, 0));
      run_iter(p, bp, 1'b0, -1, -1);
      iter_m++;
      n_checks++;
      if (!order_ok(p) || obs_ncommit != 1 || obs_cpo !== p)
        $display("FAIL rand_seq%0d: starts=%0d commits=%0d prior=%0d want pred=%0d", it,
                 obs_order.size(), obs_ncommit, obs_cpo, p);
      else n_pass++;
      n_checks++;
      if (obs_lat != ref_lat(p)) $display("FAIL rand_latency%0d: got %0d want %0d", it, obs_lat, ref_lat(p));
      else n_pass++;
      n_checks++;
      if (iter_cnt !== CNT_W'(iter_m) || err !== err_m || !obs_after_ok)
        $display("FAIL rand_state%0d: iter_cnt=%0d err=%b after=%0d want %0d/%b/1", it, iter_cnt, err,
                 obs_after_ok, iter_m, err_m);
      else n_pass++;
    end
  endtask

  task automatic test_mid_reset();
    rand_lat(3, 8);
    run_iter(1'b0, 0, 1'b0, int'(STG_GAIN), -1);
    #1;
    n_checks++;
    if ({meas_ready, busy, commit, commit_prior_only, res_valid, err} !== 6'b0 || stg_start !== '0)
      $display("FAIL midrst_outputs: ctrl=%b stg_start=%b want 0/0",
               {meas_ready, busy, commit, commit_prior_only, res_valid, err}, stg_start);
    else n_pass++;
    n_checks++;
    if (iter_cnt !== '0) $display("FAIL midrst_iter_cnt: got %0d want 0", iter_cnt);
    else n_pass++;
    iter_m = 0; err_m = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rand_lat(1, 5);
    run_iter(1'b0, 0, 1'b0, -1, -1);
    iter_m++;
    n_checks++;
    if (!order_ok(1'b0) || obs_lat != ref_lat(1'b0))
      $display("FAIL midrst_rerun: starts=%0d lat=%0d want 5/%0d", obs_order.size(), obs_lat, ref_lat(1'b0));
    else n_pass++;
    n_checks++;
    if (iter_cnt !== CNT_W'(iter_m) || err !== err_m)
      $display("FAIL midrst_counters: iter_cnt=%0d err=%b want %0d/%b", iter_cnt, err, iter_m, err_m);
    else n_pass++;
  endtask

`ifdef KF_STAGE_WDOG_EN
  task automatic test_watchdog();
    int exp_l;
    rand_lat(1, 6);
    run_iter(1'b0, 0, 1'b0, -1, int'(STG_GAIN));
    err_m = 1'b1;
    exp_l = (lat[0] + 2) + (lat[1] + 2) + int'(TMO_CYC) + 1;
    n_checks++;
    if (err !== 1'b1 || tmo_stage !== 3'd2)
      $display("FAIL wdog_flags: err=%b tmo_stage=%0d want 1/2", err, tmo_stage);
    else n_pass++;
    n_checks++;
    if (obs_ncommit != 0 || iter_cnt !== CNT_W'(iter_m))
      $display("FAIL wdog_commit: commits=%0d iter_cnt=%0d want 0/%0d", obs_ncommit, iter_cnt, iter_m);
    else n_pass++;
    n_checks++;
    if (obs_lat != exp_l || obs_order.size() != 3)
      $display("FAIL wdog_timing: lat=%0d starts=%0d want %0d/3", obs_lat, obs_order.size(), exp_l);
    else n_pass++;
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running, want finished");
    $fatal(1, "bench time limit reached");
  end

  initial begin
    test_reset();
    test_full();
    test_predict();
    test_backpressure();
    test_spurious();
    test_random();
    test_mid_reset();
`ifdef KF_STAGE_WDOG_EN
    test_watchdog();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/kf_step_ctrl.md
Name: kf_step_ctrl

Overview:
- Top-level sequencer for one 2x2 fixed-point Kalman iteration.
- Accepts a measurement handshake, then issues single-cycle start pulses in a fixed order to five stage engines and waits for each done pulse. Stage order: 0 state predict, 1 prior cov, 2 gain, 3 post state, 4 post cov (post_cov_semipar).
- Commits posterior results to the state/cov registers and presents a result handshake downstream.
- Contains no arithmetic; pure control.

Parameters:
- NSTAGE, 5, number of stage engines; index 0..NSTAGE-1 is the issue order.
- PRED_MASK, 5'b00011, stages run when predict_only=1; all other stages are skipped.
- TMO_CYC, 64, watchdog limit in cycles per stage (used only with the optional feature).
- CNT_W, 16, width of the iteration counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- meas_valid  in  1  measurement available
- predict_only  in  1  sampled with the meas handshake; selects PRED_MASK instead of all stages
- meas_ready  out  1  controller idle, can accept a measurement
- stg_start  out  NSTAGE  one-hot, single-cycle start pulse to the current stage
- stg_done  in  NSTAGE  done pulses from the stages
- commit  out  1  one-cycle load enable: x<=x_post and P<=P_post (or prior values when predict_only)
- commit_prior_only  out  1  qualifies commit; 1 selects the prior values
- res_valid  out  1  iteration result ready
- res_ready  in  1  downstream accepts the result
- busy  out  1  iteration in progress
- iter_cnt  out  CNT_W  completed iterations, wraps
- err  out  1  sticky error flag

Behaviour:
- Reset (async, rst_n=0): all outputs 0, except meas_ready=1 after reset release. State goes to IDLE, stage index 0, mask register all-ones, err=0, iter_cnt=0.
- FSM states: IDLE, ISSUE, WAIT, COMMIT, OUT.
- IDLE:
  - meas_ready=1.
  - On meas_valid&meas_ready, latch mask = predict_only ? PRED_MASK : all-ones, and latch predict_only.
  - Set idx to the lowest set mask bit and go to ISSUE. busy=1 from the next cycle.
- ISSUE:
  - Assert stg_start[idx] for exactly one cycle, then go to WAIT.
  - A start is never re-issued to a stage that has not yet returned done; post_cov ignores start while running.
- WAIT:
  - Wait for stg_done[idx].
  - A done on any other bit is spurious: set err and otherwise ignore it.
  - On done, advance idx to the next set mask bit above idx. If one exists, go to ISSUE; otherwise go to COMMIT.
  - Minimum per-stage cost is 1 ISSUE cycle plus the stage latency plus 1. A done in the same cycle as the start is legal and is accepted in the first WAIT cycle only if still asserted; stages pulse done no earlier than one cycle after start.
- COMMIT: pulse commit for one cycle, with commit_prior_only = latched predict_only. Increment iter_cnt (wrapping at 2^CNT_W). Go to OUT.
- OUT:
  - res_valid=1, held stable until res_ready.
  - On res_valid&res_ready: go to IDLE, busy=0, and meas_ready=1 in the following cycle. meas_ready is not asserted in the same cycle as the handshake.
- Full-iteration latency from meas handshake to res_valid: sum over masked stages of (stage latency + 2), plus 1.
- Reset mid-iteration: state is abandoned at once. Stages are not restarted; they share rst_n.
- err is sticky until reset.

Optional Feature:
- Macro: KF_STAGE_WDOG_EN.
- Compiled in:
  - A per-stage counter clears on ISSUE and increments in WAIT.
  - On reaching TMO_CYC-1 without done: set err, skip commit, go directly to OUT with res_valid=1.
  - Add output port tmo_stage (3 bits) holding the idx of the timed-out stage; it is 0 when no timeout occurred.
- Compiled out: no counter and no tmo_stage port; WAIT waits indefinitely.

Decomposition:
- Shared fxp_types.vh / kf_ctrl_pkg holds:
  - Stage index constants STG_PRED=0, STG_PCOV=1, STG_GAIN=2, STG_XPOST=3, STG_PPOST=4.
  - FSM state encodings.
  - Default PRED_MASK.
- Natural sub-module: kf_next_stage, a combinational priority finder returning the next set mask bit above idx plus a none flag.
- The FSM stays in kf_step_ctrl.

Test Plan:
- Full iteration, each stage model answering done 8 cycles after start:
  - Five start pulses in order 0..4, one each.
  - commit=1 with commit_prior_only=0.
  - res_valid rises 51 cycles after the meas handshake.
  - iter_cnt=1.
- predict_only=1: only stg_start[0] and stg_start[1] pulse; commit_prior_only=1; res_valid after 21 cycles.
- Backpressure: res_ready held 0 for 10 cycles.
  - res_valid stays 1 and meas_ready stays 0 throughout.
  - meas_ready=1 one cycle after the handshake.
- Spurious done[3] injected while waiting on stage 1: err=1, sequence still completes normally.
- Assert rst_n=0 while in WAIT on stage 2: all outputs 0 immediately; after release, a new iteration works and iter_cnt restarts at 0.
- KF_STAGE_WDOG_EN with stage 2 never responding:
  - At the TMO_CYC limit: err=1 and tmo_stage=2.
  - No commit pulse; res_valid=1.
